// File: rtl/urv_pipe_pkg.sv
// urv_pipe_pkg: pipeline control FSM states and default geometry.
package urv_pipe_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;
  localparam int DEF_NUM_STAGES   = 4;
  localparam int DEF_BRANCH_STAGE = 2;
endpackage

// File: rtl/urv_kill_shadow.sv
// urv_kill_shadow: remembers recent taken branches so younger stages up to the
// branch stage get killed as the wrong-path instructions advance.
module urv_kill_shadow #(
  parameter int g_depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             shift_en,
  input  logic             branch,
  output logic [g_depth:0] kill,
  output logic             busy
);
  logic [g_depth-1:0] d;
  logic acc;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) d <= '0;
    else if (shift_en) begin
      d[0] <= branch;
      for (int i = 1; i < g_depth; i++) d[i] <= d[i-1];
    end
  end
  always_comb begin
    kill = '0;
    acc  = branch;
    for (int k = 1; k <= g_depth; k++) begin
      acc     = acc | d[k-1];
      kill[k] = acc;
    end
  end
  assign busy = |d;
endmodule

// File: rtl/urv_pipe_ctrl.sv
// urv_pipe_ctrl: per-stage stall/kill generation plus halt/drain handshake.
// Optional performance counters are enabled by defining URV_PIPE_PERF_EN.
module urv_pipe_ctrl
  import urv_pipe_pkg::*;
#(
  parameter int g_num_stages   = DEF_NUM_STAGES,
  parameter int g_branch_stage = DEF_BRANCH_STAGE
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [g_num_stages-1:0] stall_req_i,
  input  logic [g_num_stages-1:0] stage_valid_i,
  input  logic                    branch_i,
  input  logic                    halt_req_i,
  output logic [g_num_stages-1:0] stall_o,
  output logic [g_num_stages-1:0] kill_o,
`ifdef URV_PIPE_PERF_EN
  output logic [31:0]             perf_stall_cnt_o,
  output logic [31:0]             perf_kill_cnt_o,
`endif
  output logic                    halt_ack_o
);
  localparam int N = g_num_stages;
  localparam int B = g_branch_stage;
  state_e state, state_nx;
  logic [N-1:0] stall_raw;
  logic [B:0] kill_b;
  logic shadow_busy, acc;
  logic unused_ok;
  assign unused_ok = stage_valid_i[0];
  // a stage stalls when anything downstream of it is stalled
  always_comb begin
    stall_raw = '0;
    acc       = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      stall_raw[k] = acc;
      acc          = acc | stall_req_i[k];
    end
  end
  assign stall_o = {stall_raw[N-1:1], stall_raw[0] | (state != ST_RUN)};
  urv_kill_shadow #(.g_depth(B)) u_shadow (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .shift_en (~stall_o[B]),
    .branch   (branch_i),
    .kill     (kill_b),
    .busy     (shadow_busy)
  );
  assign kill_o = {{(N-1-B){1'b0}}, kill_b};
  // a branch arriving in the final drain cycle would still load the shadow
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:    state_nx = halt_req_i ? ST_DRAIN : ST_RUN;
      ST_DRAIN:  state_nx = !halt_req_i ? ST_RUN :
                            (stage_valid_i[N-1:1] == '0 && !shadow_busy && !branch_i) ? ST_HALTED : ST_DRAIN;
      ST_HALTED: state_nx = halt_req_i ? ST_HALTED : ST_RUN;
      default:   state_nx = ST_RUN;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_RUN;
      halt_ack_o <= 1'b0;
    end else begin
      state      <= state_nx;
      halt_ack_o <= state_nx == ST_HALTED;
    end
  end
`ifdef URV_PIPE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_stall_cnt_o <= '0;
      perf_kill_cnt_o  <= '0;
    end else begin
      if (stall_o[0]) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (|kill_o) perf_kill_cnt_o <= perf_kill_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// tb_urv_pipe_ctrl: directed checks of stall/kill/halt behaviour at N=4, B=2.
module tb_urv_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] stall_req, stage_valid, stall, kill;
  logic branch, halt_req, halt_ack;
  int n_checks = 0;
  int n_fail = 0;
`ifdef URV_PIPE_PERF_EN
  logic [31:0] perf_stall, perf_kill;
`endif
  always #5 clk = ~clk;
  urv_pipe_ctrl dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .stall_req_i      (stall_req),
    .stage_valid_i    (stage_valid),
    .branch_i         (branch),
    .halt_req_i       (halt_req),
    .stall_o          (stall),
    .kill_o           (kill),
`ifdef URV_PIPE_PERF_EN
    .perf_stall_cnt_o (perf_stall),
    .perf_kill_cnt_o  (perf_kill),
`endif
    .halt_ack_o       (halt_ack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; stall_req = '0; stage_valid = '0; branch = 1'b0; halt_req = 1'b0;
    #3;
    check("rst_ack", 32'(halt_ack), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_kill", 32'(kill), 32'd0);
`ifdef URV_PIPE_PERF_EN
    check("rst_pstall", perf_stall, 32'd0);
    check("rst_pkill", perf_kill, 32'd0);
`endif
    step(); step();
    rst_n = 1'b1;
    // downstream stall propagation
    stall_req = 4'b0100; mid();
    check("st_0100", 32'(stall), 32'h3);
    check("st_0100_kill", 32'(kill), 32'h0);
    stall_req = 4'b1000; #1; check("st_1000", 32'(stall), 32'h7);
    stall_req = 4'b0001; #1; check("st_0001", 32'(stall), 32'h0);
    stall_req = 4'b0010; #1; check("st_0010", 32'(stall), 32'h1);
    stall_req = 4'b1111; #1; check("st_1111", 32'(stall), 32'h7);
    step(); stall_req = '0;
    // single branch, free-flowing pipe
    branch = 1'b1; mid(); check("br_c0", 32'(kill), 32'h6);
    step(); branch = 1'b0; mid(); check("br_c1", 32'(kill), 32'h6);
    step(); mid(); check("br_c2", 32'(kill), 32'h4);
    step(); mid(); check("br_c3", 32'(kill), 32'h0);
    // branch followed by a writeback stall that freezes the shadow
    step(); branch = 1'b1; mid(); check("brs_c0", 32'(kill), 32'h6);
    step(); branch = 1'b0; stall_req = 4'b1000;
    for (int i = 1; i <= 3; i++) begin
      mid();
      check($sformatf("brs_hold%0d", i), 32'(kill), 32'h6);
      check($sformatf("brs_stall%0d", i), 32'(stall), 32'h7);
      step();
    end
    stall_req = '0; mid(); check("brs_c4", 32'(kill), 32'h6);
    step(); mid(); check("brs_c5", 32'(kill), 32'h4);
    step(); mid(); check("brs_c6", 32'(kill), 32'h0);
    // halt with stages draining one per cycle
    step(); halt_req = 1'b1; stage_valid = 4'b1110; mid();
    check("h_c0_stall", 32'(stall), 32'h0);
    check("h_c0_ack", 32'(halt_ack), 32'h0);
    step(); stage_valid = 4'b1100; mid();
    check("h_c1_stall", 32'(stall), 32'h1);
    check("h_c1_ack", 32'(halt_ack), 32'h0);
    step(); stage_valid = 4'b1000; mid(); check("h_c2_ack", 32'(halt_ack), 32'h0);
    step(); stage_valid = 4'b0000; mid();
    check("h_c3_ack", 32'(halt_ack), 32'h0);
    check("h_c3_stall", 32'(stall), 32'h1);
    step(); mid();
    check("h_c4_ack", 32'(halt_ack), 32'h1);
    check("h_c4_stall", 32'(stall), 32'h1);
    halt_req = 1'b0;
    step(); mid();
    check("h_rel_ack", 32'(halt_ack), 32'h0);
    check("h_rel_stall", 32'(stall), 32'h0);
    // halt request withdrawn while draining
    step(); halt_req = 1'b1; stage_valid = 4'b0010;
    step(); mid(); check("ab_c1_stall", 32'(stall), 32'h1);
    halt_req = 1'b0;
    step(); mid();
    check("ab_c2_stall", 32'(stall), 32'h0);
    check("ab_c2_ack", 32'(halt_ack), 32'h0);
    // branch at halt entry delays HALTED until the shadow clears
    step(); stage_valid = '0; halt_req = 1'b1; branch = 1'b1; mid();
    check("bd_c0_kill", 32'(kill), 32'h6);
    step(); branch = 1'b0; mid();
    check("bd_c1_kill", 32'(kill), 32'h6);
    check("bd_c1_ack", 32'(halt_ack), 32'h0);
    step(); mid();
    check("bd_c2_kill", 32'(kill), 32'h4);
    check("bd_c2_ack", 32'(halt_ack), 32'h0);
    step(); mid(); check("bd_c3_ack", 32'(halt_ack), 32'h0);
    step(); mid(); check("bd_c4_ack", 32'(halt_ack), 32'h1);
    // asynchronous reset while halted
    rst_n = 1'b0; #1;
    check("ar_ack", 32'(halt_ack), 32'h0);
    check("ar_stall", 32'(stall), 32'h0);
    step(); rst_n = 1'b1;
    step(); mid(); check("ar_redrain", 32'(stall), 32'h1);
    halt_req = 1'b0;
    step(); mid(); check("ar_run", 32'(stall), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
